// File: rtl/mine_scheduler.sv
// Mine spawn scheduler: paces spawn attempts by frame count and caps the number of active mines.
// Optional feature: define MINE_SCHED_AVOID_REPEAT_EN to rotate away from the last acknowledged direction.
module mine_scheduler #(
  parameter int unsigned SPAWN_PERIOD = 60,
  parameter int unsigned MAX_MINES    = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic [2:0] random,
  input  logic       spawn_ack,
  input  logic       mine_cleared,
  output logic       spawn_req,
  output logic [3:0] spawn_dir,
  output logic [2:0] active_count,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_REQ    = 2'd3;

  localparam logic [7:0] LAST_FRAME = 8'(SPAWN_PERIOD - 1);
  localparam logic [2:0] MAX_COUNT  = 3'(MAX_MINES);

  logic [1:0] state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       req_q, req_d;
  logic [3:0] dir_q, dir_d;
  logic [2:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic [3:0] decoded_dir;
  logic [3:0] chosen_dir;
  logic       spawn_done;

  always_comb begin
    decoded_dir = 4'b1000;
    case (random)
      3'b001:  decoded_dir = 4'b0001;
      3'b010:  decoded_dir = 4'b0010;
      3'b011:  decoded_dir = 4'b0100;
      default: decoded_dir = 4'b1000;
    endcase
  end

`ifdef MINE_SCHED_AVOID_REPEAT_EN
  logic [3:0] last_dir_q, last_dir_d;

  // last_dir resets to zero, which never matches a one-hot decode
  assign chosen_dir = (decoded_dir == last_dir_q) ? {decoded_dir[2:0], decoded_dir[3]}
                                                  : decoded_dir;

  always_comb begin
    last_dir_d = last_dir_q;
    if (spawn_done) begin
      last_dir_d = dir_q;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_dir_q <= 4'b0000;
    end else begin
      last_dir_q <= last_dir_d;
    end
  end
`else
  assign chosen_dir = decoded_dir;
`endif

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    req_d       = req_q;
    dir_d       = dir_q;
    spawn_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d     = S_IDLE;
          frame_cnt_d = 8'd0;
        end else if (startOfFrame) begin
          if (frame_cnt_q == LAST_FRAME) begin
            frame_cnt_d = 8'd0;
            state_d     = S_SAMPLE;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      S_SAMPLE: begin
        // a pause takes priority over launching a request
        if (!enable) begin
          state_d     = S_IDLE;
          frame_cnt_d = 8'd0;
        end else if (count_q == MAX_COUNT) begin
          state_d = S_WAIT;
        end else begin
          dir_d   = chosen_dir;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        if (spawn_ack) begin
          spawn_done = 1'b1;
          req_d      = 1'b0;
          dir_d      = 4'b0000;
          state_d    = enable ? S_WAIT : S_IDLE;
        end
      end
    endcase
  end

  // simultaneous spawn and clear cancel out
  always_comb begin
    count_d = count_q;
    if (spawn_done && !mine_cleared) begin
      count_d = count_q + 3'd1;
    end else if (!spawn_done && mine_cleared && (count_q != 3'd0)) begin
      count_d = count_q - 3'd1;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= 8'd0;
      req_q       <= 1'b0;
      dir_q       <= 4'b0000;
      count_q     <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      req_q       <= req_d;
      dir_q       <= dir_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
    end
  end

  assign spawn_req    = req_q;
  assign spawn_dir    = dir_q;
  assign active_count = count_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mine_scheduler.sv
// Directed bench for mine_scheduler with SPAWN_PERIOD=3 and MAX_MINES=2.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_mine_scheduler;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] random = 3'b000;
  logic       spawn_ack = 1'b0;
  logic       mine_cleared = 1'b0;
  logic       spawn_req;
  logic [3:0] spawn_dir;
  logic [2:0] active_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mine_scheduler #(.SPAWN_PERIOD(3), .MAX_MINES(2)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .random       (random),
    .spawn_ack    (spawn_ack),
    .mine_cleared (mine_cleared),
    .spawn_req    (spawn_req),
    .spawn_dir    (spawn_dir),
    .active_count (active_count),
    .busy         (busy)
  );

  task automatic frame();
    @(negedge clk) startOfFrame = 1'b1;
    @(negedge clk) startOfFrame = 1'b0;
  endtask

  task automatic three_frames();
    frame(); frame(); frame();
  endtask

  task automatic ack();
    spawn_ack = 1'b1;
    @(negedge clk) spawn_ack = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk) mine_cleared = 1'b1;
    @(negedge clk) mine_cleared = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", spawn_req); end
    checks++; if (spawn_dir !== 4'b0000) begin errors++; $display("FAIL reset_dir got %b want 0000", spawn_dir); end
    checks++; if (active_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", active_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk) resetN = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_disabled_busy got %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_period_decode();
    enable = 1'b1;
    random = 3'b010;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL leave_idle_busy got %b want 1", busy); end
    frame(); frame();
    checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL early_req got %b want 0", spawn_req); end
    frame();
    checks++; if (spawn_req !== 1'b0 || spawn_dir !== 4'b0000) begin errors++; $display("FAIL sample_req got %b/%b want 0/0000", spawn_req, spawn_dir); end
    @(negedge clk);
    checks++; if (spawn_req !== 1'b1 || spawn_dir !== 4'b0010) begin errors++; $display("FAIL period_req got %b/%b want 1/0010", spawn_req, spawn_dir); end
    ack();
    checks++; if (spawn_req !== 1'b0 || spawn_dir !== 4'b0000) begin errors++; $display("FAIL ack_drop got %b/%b want 0/0000", spawn_req, spawn_dir); end
    checks++; if (active_count !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL ack_count got %0d/%b want 1/1", active_count, busy); end
    $display("test_period_decode done");
  endtask

  task automatic test_occupancy();
    random = 3'b011;
    three_frames();
    @(negedge clk);
    checks++; if (spawn_req !== 1'b1 || spawn_dir !== 4'b0100) begin errors++; $display("FAIL occ_second_req got %b/%b want 1/0100", spawn_req, spawn_dir); end
    ack();
    checks++; if (active_count !== 3'd2) begin errors++; $display("FAIL occ_count got %0d want 2", active_count); end
    random = 3'b001;
    three_frames();
    repeat (3) begin
      @(negedge clk);
      checks++; if (spawn_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL occ_full_req got %b/%b want 0/1", spawn_req, busy); end
    end
    clear_pulse();
    checks++; if (active_count !== 3'd1) begin errors++; $display("FAIL occ_clear_count got %0d want 1", active_count); end
    three_frames();
    @(negedge clk);
    checks++; if (spawn_req !== 1'b1 || spawn_dir !== 4'b0001) begin errors++; $display("FAIL occ_resume_req got %b/%b want 1/0001", spawn_req, spawn_dir); end
    $display("test_occupancy done");
  endtask

  task automatic test_collision();
    spawn_ack = 1'b1;
    mine_cleared = 1'b1;
    @(negedge clk);
    spawn_ack = 1'b0;
    mine_cleared = 1'b0;
    checks++; if (active_count !== 3'd1 || spawn_req !== 1'b0) begin errors++; $display("FAIL collide_count got %0d/%b want 1/0", active_count, spawn_req); end
    clear_pulse();
    checks++; if (active_count !== 3'd0) begin errors++; $display("FAIL clear_to_zero got %0d want 0", active_count); end
    clear_pulse();
    checks++; if (active_count !== 3'd0) begin errors++; $display("FAIL underflow got %0d want 0", active_count); end
    @(negedge clk) spawn_ack = 1'b1;
    @(negedge clk) spawn_ack = 1'b0;
    checks++; if (active_count !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL stray_ack got %0d/%b want 0/1", active_count, busy); end
    $display("test_collision done");
  endtask

  task automatic test_pause_req();
    random = 3'b000;
    three_frames();
    @(negedge clk);
    checks++; if (spawn_req !== 1'b1 || spawn_dir !== 4'b1000) begin errors++; $display("FAIL pause_req_rise got %b/%b want 1/1000", spawn_req, spawn_dir); end
    enable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++; if (spawn_req !== 1'b1 || spawn_dir !== 4'b1000) begin errors++; $display("FAIL pause_req_hold got %b/%b want 1/1000", spawn_req, spawn_dir); end
    end
    ack();
    checks++; if (spawn_req !== 1'b0 || busy !== 1'b0 || active_count !== 3'd1) begin errors++; $display("FAIL pause_ack got %b/%b/%0d want 0/0/1", spawn_req, busy, active_count); end
    $display("test_pause_req done");
  endtask

  task automatic test_pause_wait();
    enable = 1'b1;
    @(negedge clk);
    frame();
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pause_wait_busy got %b want 0", busy); end
    enable = 1'b1;
    @(negedge clk);
    frame(); frame();
    @(negedge clk);
    checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL pause_wait_restart got %b want 0", spawn_req); end
    frame();
    @(negedge clk);
    checks++; if (spawn_req !== 1'b1) begin errors++; $display("FAIL pause_wait_req got %b want 1", spawn_req); end
    $display("test_pause_wait done");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    checks++; if (spawn_req !== 1'b0 || spawn_dir !== 4'b0000) begin errors++; $display("FAIL areset_req got %b/%b want 0/0000", spawn_req, spawn_dir); end
    checks++; if (active_count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL areset_count got %0d/%b want 0/0", active_count, busy); end
    @(negedge clk);
    resetN = 1'b1;
    enable = 1'b0;
    spawn_ack = 1'b1;
    @(negedge clk) spawn_ack = 1'b0;
    checks++; if (active_count !== 3'd0 || spawn_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_ack got %0d/%b/%b want 0/0/0", active_count, spawn_req, busy); end
    $display("test_async_reset done");
  endtask

  task automatic test_repeat();
    logic [3:0] want_second;
`ifdef MINE_SCHED_AVOID_REPEAT_EN
    want_second = 4'b0001;
`else
    want_second = 4'b1000;
`endif
    enable = 1'b1;
    random = 3'b111;
    @(negedge clk);
    three_frames();
    @(negedge clk);
    checks++; if (spawn_dir !== 4'b1000) begin errors++; $display("FAIL repeat_first got %b want 1000", spawn_dir); end
    ack();
    three_frames();
    @(negedge clk);
    checks++; if (spawn_req !== 1'b1 || spawn_dir !== want_second) begin errors++; $display("FAIL repeat_second got %b/%b want 1/%b", spawn_req, spawn_dir, want_second); end
    ack();
    checks++; if (active_count !== 3'd2) begin errors++; $display("FAIL repeat_count got %0d want 2", active_count); end
    $display("test_repeat done");
  endtask

  initial begin
    test_reset();
    test_period_decode();
    test_occupancy();
    test_collision();
    test_pause_req();
    test_pause_wait();
    test_async_reset();
    test_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mine_scheduler.md
MINE_SCHEDULER -- requirements
Module: mine_scheduler

Interface
REQ-001 Parameter SPAWN_PERIOD, default 60; frames between spawn attempts, legal range 1..255.
REQ-002 Parameter MAX_MINES, default 4; maximum simultaneously active mines, legal range 1..7.
REQ-003 clk  input  1  system clock; the single clock of the block.
REQ-004 resetN  input  1  reset; asynchronous, active-low.
REQ-005 startOfFrame  input  1  one-cycle pulse, once per video frame.
REQ-006 enable  input  1  game-running level; low pauses scheduling.
REQ-007 random  input  3  free-running random value, sampled in SAMPLE state.
REQ-008 spawn_ack  input  1  one-cycle pulse from game logic; mine placed.
REQ-009 mine_cleared  input  1  one-cycle pulse; one active mine destroyed.
REQ-010 spawn_req  output  1  spawn request, held until acknowledged.
REQ-011 spawn_dir  output  4  one-hot spawn direction, valid while spawn_req=1.
REQ-012 active_count  output  3  current number of active mines.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, WAIT, SAMPLE and REQ; all outputs are registered.
REQ-015 IDLE -> WAIT SHALL occur on the first clk edge with enable=1.
REQ-016 In WAIT, an 8-bit frame counter SHALL increment on each startOfFrame; on startOfFrame with counter = SPAWN_PERIOD-1, the counter SHALL clear and the FSM SHALL go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle.
REQ-018 In SAMPLE, if active_count = MAX_MINES, the attempt SHALL be dropped and the FSM SHALL return to WAIT.
REQ-019 Otherwise, SAMPLE SHALL latch the decoded direction into spawn_dir and go to REQ.
REQ-020 Decode rule: random 3'b001 -> 4'b0001; 3'b010 -> 4'b0010; 3'b011 -> 4'b0100; any other value -> 4'b1000.
REQ-021 In REQ, spawn_req=1 and spawn_dir SHALL stay stable until spawn_ack is sampled high.
REQ-022 On that spawn_ack edge: spawn_req drops; active_count increments; next state is WAIT if enable=1, else IDLE.
REQ-023 spawn_ack outside REQ SHALL be ignored.
REQ-024 spawn_dir SHALL read 4'b0000 whenever spawn_req=0.
REQ-025 mine_cleared SHALL decrement active_count in any state; mine_cleared at active_count=0 SHALL be ignored (no wrap).
REQ-026 spawn_ack and mine_cleared in the same cycle SHALL leave active_count unchanged.
REQ-027 enable=0 in WAIT or SAMPLE SHALL force IDLE next cycle and clear the frame counter.
REQ-028 enable=0 in REQ SHALL NOT abandon the request; REQ waits for spawn_ack.
REQ-029 active_count SHALL persist through IDLE; only reset clears it.
REQ-030 The first spawn attempt after leaving IDLE SHALL occur on the SPAWN_PERIOD-th startOfFrame.

Reset
REQ-031 resetN=0 SHALL asynchronously force IDLE, clear the frame counter, and set spawn_req=0, spawn_dir=4'b0000, active_count=0, busy=0 and the last-direction register to 4'b0000.
REQ-032 Reset asserted mid-REQ SHALL drop the request immediately; a later spawn_ack SHALL be ignored.

Configuration
REQ-033 Macro MINE_SCHED_AVOID_REPEAT_EN, when defined: if the decoded direction equals the last acknowledged direction, the latched direction SHALL be the decoded value rotated left by one bit (4'b1000 -> 4'b0001).
REQ-034 MINE_SCHED_AVOID_REPEAT_EN, when undefined: the decoded direction SHALL be used unmodified, and no last-direction register SHALL exist.

Verification
REQ-035 Period and decode: SPAWN_PERIOD=3, enable=1, random=3'b010 -> spawn_req rises after the 3rd startOfFrame with spawn_dir=4'b0010; ack -> active_count=1.
REQ-036 Occupancy limit: MAX_MINES=2, two acked spawns -> next period has no spawn_req; one mine_cleared pulse -> following period requests again.
REQ-037 Counter collision and underflow: spawn_ack and mine_cleared in the same cycle at count 1 -> count stays 1; mine_cleared at count 0 -> count stays 0.
REQ-038 Pause during request: enable drops during REQ -> spawn_req held for 5 cycles until ack, then IDLE with busy=0.
REQ-039 Async reset: resetN pulsed low mid-REQ between clk edges -> outputs clear immediately; a subsequent spawn_ack does not change active_count.
REQ-040 With MINE_SCHED_AVOID_REPEAT_EN defined: random=3'b111 on two consecutive spawns -> spawn_dir 4'b1000, then 4'b0001.
